vga_bitgen: RTL
===============

# vga_bitgen

Pixel-generation stage directly downstream of the VGA sync/timing controller. Consumes the controller's `hCount`/`vCount`/`bright`/`hSync`/`vSync` and renders an 80x60 text/tile screen of 8x8-pixel cells. It uses an external tile-map RAM and glyph ROM. It outputs 8-bit RGB with the sync signals delayed to stay pixel-aligned. A frame-synchronous color-register write port lets the CPU change foreground/background colors without tearing.

## Interface
Parameters:
- `COLS`, 80, tiles per row (640/8)
- `ROWS`, 60, tile rows (480/8)
- `FG_RESET`, 8'hFF, foreground color after reset
- `BG_RESET`, 8'h00, background color after reset

Ports:
- `clock`  in  1  pixel clock (25 MHz)
- `clear`  in  1  reset; asynchronous, active-low (asserted when 0)
- `hCount`  in  10  pixel column from timing controller, valid 0..639 when `bright`=1
- `vCount`  in  10  pixel row from timing controller, valid 0..479 when `bright`=1
- `bright`  in  1  active-video flag from timing controller
- `hSync`, `vSync`  in  1 each  active-low syncs from timing controller
- `tileAddr`  out  13  tile-map RAM read address, row*80+col
- `tileRe`  out  1  tile-map read enable
- `tileData`  in  8  tile-map RAM data, 1-cycle read latency; bit7 = invert, bits6:0 = glyph
- `glyphAddr`  out  10  glyph ROM address {glyph[6:0], pixelRow[2:0]}
- `glyphData`  in  8  glyph ROM row bitmap, 1-cycle latency; bit7 = leftmost pixel
- `colorWe`  in  1  color write strobe
- `colorData`  in  16  {fg[7:0], bg[7:0]}
- `colorPending`  out  1  write captured, not yet committed
- `rgb`  out  8  pixel color (RRRGGGBB)
- `hSyncOut`, `vSyncOut`, `brightOut`  out  1 each  inputs delayed to align with `rgb`

## Operation
- Pipeline of 3 registered stages. S0, S1 and S2 each carry `bright`, `hSync`, `vSync` and `hCount[2:0]`.
- S0, issue: when `bright`=1:
  - `tileRe`=1.
  - `tileAddr` = (vCount[9:3]<<6)+(vCount[9:3]<<4)+hCount[9:3]. Width is 13 bits with no overflow; the maximum is 4799.
  - When `bright`=0: `tileRe`=0 and `tileAddr` holds its last value.
- S1, glyph fetch: `glyphAddr` = {tileData[6:0], vCount_d1[2:0]}. Register `tileData[7]` as the invert flag.
- S2, pixel select: bit = glyphData[7 - col_d2]; flip the bit if invert_d2 is set.
- Output register: `rgb` = bit ? fg : bg when bright_d3=1, else 8'h00.
- Color registers:
  - `colorWe`=1 loads `colorData` into the pending fg/bg and sets `colorPending`.
  - Commit happens on a vSync falling edge, detected as registered vSync_d1=1 and vSync=0. If pending is set, active fg/bg <= pending and pending is cleared.
  - `colorWe` in the commit cycle: the commit uses the old pending value. The new write is captured and `colorPending` stays 1.
  - Back-to-back writes before a commit: the last write wins.
- `clear`=0 at any time resets immediately:
  - rgb=0, brightOut=0, hSyncOut=1, vSyncOut=1, tileRe=0, tileAddr=0, glyphAddr=0, colorPending=0.
  - Active fg=FG_RESET, bg=BG_RESET; pipeline flags cleared.
  - A frame in progress is abandoned. Output resumes correctly on the first `bright` after release.

## Timing
- Input sample at edge t -> `rgb`/`hSyncOut`/`vSyncOut`/`brightOut` valid after edge t+3. Latency is fixed at 3 cycles for every signal, including sync.
- One pixel per clock, no stalls, no backpressure. The external memories must meet 1-cycle latency.
- Color commit takes effect on pixels entering S0 from the cycle after the vSync falling edge. That edge is inside vertical blanking, so no visible pixel changes mid-frame.
- `colorPending` rises the cycle after `colorWe` and falls the cycle after the commit edge.

## Test plan
- Reset: hold `clear`=0 with toggling inputs -> rgb=00, hSyncOut=vSyncOut=1, brightOut=0, tileRe=0. Release, then drive bright=1 at h=0,v=0 -> tileAddr=0 and tileRe=1 at t+1; first rgb at t+3.
- Addressing: h=639,v=479 -> tileAddr=4799. h=8,v=8 -> tileAddr=81. bright=0 -> tileRe=0 and tileAddr unchanged.
- Rendering: tileData=8'h41 and glyphData=8'b1000_0001 for row 0 -> pixels h=0 and h=7 are FF, h=1..6 are 00. Same case with tileData=8'hC1 -> pattern inverted.
- Alignment: random hSync/vSync/bright stream -> outputs equal the inputs delayed exactly 3 cycles. rgb=00 whenever brightOut=0.
- Color commit: write 16'hE003 mid-frame -> colors unchanged and colorPending=1. After the vSync falling edge, visible pixels use fg=E0, bg=03 and colorPending=0.
- Simultaneous events: write A, then write B in the exact commit cycle -> A committed, B pending and colorPending=1. Assert `clear` mid-line -> outputs reset asynchronously the same cycle.

Source files
------------

// File: rtl/vga_bitgen.sv
// Pixel generator for an 80x60 grid of 8x8 tiles, placed behind the VGA timing controller.
// Tile map and glyph ROM lookups run in a fixed 3-cycle pipeline. Frame-synchronous colour registers feed that pipeline.
module vga_bitgen #(
    parameter int         COLS     = 80,
    parameter int         ROWS     = 60,
    parameter logic [7:0] FG_RESET = 8'hFF,
    parameter logic [7:0] BG_RESET = 8'h00
) (
    input  logic        clock,
    input  logic        clear,
    input  logic [9:0]  hCount,
    input  logic [9:0]  vCount,
    input  logic        bright,
    input  logic        hSync,
    input  logic        vSync,
    output logic [12:0] tileAddr,
    output logic        tileRe,
    input  logic [7:0]  tileData,
    output logic [9:0]  glyphAddr,
    input  logic [7:0]  glyphData,
    input  logic        colorWe,
    input  logic [15:0] colorData,
    output logic        colorPending,
    output logic [7:0]  rgb,
    output logic        hSyncOut,
    output logic        vSyncOut,
    output logic        brightOut
);

    logic [6:0]  tile_row;
    logic [6:0]  tile_col;
    logic [12:0] tile_addr_calc;
    logic        tile_in_range;

    logic [12:0] tile_addr_q, tile_addr_d;
    logic        tile_re_q, tile_re_d;
    logic        s0_bright_q, s0_hsync_q, s0_vsync_q;
    logic [2:0]  s0_col_q, s0_prow_q;

    logic        s1_bright_q, s1_hsync_q, s1_vsync_q;
    logic [2:0]  s1_col_q, s1_prow_q;

    logic        s2_bright_q, s2_hsync_q, s2_vsync_q, s2_invert_q;
    logic [2:0]  s2_col_q;

    logic [7:0]  rgb_q, rgb_d;
    logic        hsync_out_q, vsync_out_q, bright_out_q;
    logic        pixel_bit;

    logic [7:0]  fg_q, fg_d, bg_q, bg_d;
    logic [7:0]  pend_fg_q, pend_fg_d, pend_bg_q, pend_bg_d;
    logic        pending_q, pending_d;
    logic        commit;

    // The row*COLS product becomes shift-add for 80 columns. The range guard prevents reads past the end of the map.
    always_comb begin
        tile_row       = vCount[9:3];
        tile_col       = hCount[9:3];
        tile_addr_calc = 13'(tile_row) * 13'(COLS) + 13'(tile_col);
        tile_in_range  = (int'(tile_row) < ROWS) && (int'(tile_col) < COLS);
        tile_addr_d    = tile_addr_q;
        tile_re_d      = 1'b0;
        if (bright && tile_in_range) begin
            tile_re_d   = 1'b1;
            tile_addr_d = tile_addr_calc;
        end
    end

    assign glyphAddr = s1_bright_q ? {tileData[6:0], s1_prow_q} : 10'd0;

    always_comb begin
        pixel_bit = glyphData[3'd7 - s2_col_q] ^ s2_invert_q;
        rgb_d     = 8'h00;
        if (s2_bright_q) begin
            rgb_d = pixel_bit ? fg_q : bg_q;
        end
    end

    // The commit point is the vSync falling edge, which falls inside vertical blanking.
    // If a write arrives in that same cycle, it refills the pending slot after the old value is committed.
    always_comb begin
        commit    = s0_vsync_q && !vSync && pending_q;
        fg_d      = fg_q;
        bg_d      = bg_q;
        pend_fg_d = pend_fg_q;
        pend_bg_d = pend_bg_q;
        pending_d = pending_q;
        if (commit) begin
            fg_d      = pend_fg_q;
            bg_d      = pend_bg_q;
            pending_d = 1'b0;
        end
        if (colorWe) begin
            pend_fg_d = colorData[15:8];
            pend_bg_d = colorData[7:0];
            pending_d = 1'b1;
        end
    end

    always_ff @(posedge clock or negedge clear) begin
        if (!clear) begin
            tile_addr_q  <= 13'd0;
            tile_re_q    <= 1'b0;
            s0_bright_q  <= 1'b0;
            s0_hsync_q   <= 1'b1;
            s0_vsync_q   <= 1'b1;
            s0_col_q     <= 3'd0;
            s0_prow_q    <= 3'd0;
            s1_bright_q  <= 1'b0;
            s1_hsync_q   <= 1'b1;
            s1_vsync_q   <= 1'b1;
            s1_col_q     <= 3'd0;
            s1_prow_q    <= 3'd0;
            s2_bright_q  <= 1'b0;
            s2_hsync_q   <= 1'b1;
            s2_vsync_q   <= 1'b1;
            s2_col_q     <= 3'd0;
            s2_invert_q  <= 1'b0;
            rgb_q        <= 8'h00;
            hsync_out_q  <= 1'b1;
            vsync_out_q  <= 1'b1;
            bright_out_q <= 1'b0;
            fg_q         <= FG_RESET;
            bg_q         <= BG_RESET;
            pend_fg_q    <= FG_RESET;
            pend_bg_q    <= BG_RESET;
            pending_q    <= 1'b0;
        end else begin
            tile_addr_q  <= tile_addr_d;
            tile_re_q    <= tile_re_d;
            s0_bright_q  <= bright;
            s0_hsync_q   <= hSync;
            s0_vsync_q   <= vSync;
            s0_col_q     <= hCount[2:0];
            s0_prow_q    <= vCount[2:0];
            s1_bright_q  <= s0_bright_q;
            s1_hsync_q   <= s0_hsync_q;
            s1_vsync_q   <= s0_vsync_q;
            s1_col_q     <= s0_col_q;
            s1_prow_q    <= s0_prow_q;
            s2_bright_q  <= s1_bright_q;
            s2_hsync_q   <= s1_hsync_q;
            s2_vsync_q   <= s1_vsync_q;
            s2_col_q     <= s1_col_q;
            s2_invert_q  <= tileData[7];
            rgb_q        <= rgb_d;
            hsync_out_q  <= s2_hsync_q;
            vsync_out_q  <= s2_vsync_q;
            bright_out_q <= s2_bright_q;
            fg_q         <= fg_d;
            bg_q         <= bg_d;
            pend_fg_q    <= pend_fg_d;
            pend_bg_q    <= pend_bg_d;
            pending_q    <= pending_d;
        end
    end

    assign tileAddr     = tile_addr_q;
    assign tileRe       = tile_re_q;
    assign rgb          = rgb_q;
    assign hSyncOut     = hsync_out_q;
    assign vSyncOut     = vsync_out_q;
    assign brightOut    = bright_out_q;
    assign colorPending = pending_q;

endmodule
